ex_pipe: RTL and testbench

EX_PIPE -- requirements
Module: ex_pipe

---
 rtl/ex_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_ex_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe.sv
// Integer execute pipe: ALU/branch/jump ops complete in 1 cycle through a single valid/ready output register.
// Flush clears the held result and kills any in-flight op. With EX_PIPE_MULDIV_EN, class 7 runs an iterative M unit (XLEN+1 cycles).
module ex_pipe #(
    parameter int XLEN    = 32,
    parameter int Q_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9:0]         op,
    input  logic [XLEN-1:0]    V1,
    input  logic [XLEN-1:0]    V2,
    input  logic [XLEN-1:0]    immediate,
    input  logic [XLEN-1:0]    npc,
    input  logic [Q_WIDTH-1:0] tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_V,
    output logic [XLEN-1:0]    out_true_pc,
    output logic [Q_WIDTH-1:0] out_tag,
    output logic               out_jump
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [2:0]      cls, sub;
    logic            accept, idle, start_md;
    logic [XLEN-1:0] res_v, res_pc;
    logic            res_jump, br_ok, br_taken;

    assign cls      = op[9:7];
    assign sub      = op[6:4];
    assign in_ready = !rst && !flush && idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    function automatic logic [XLEN-1:0] alu(input logic [3:0] code, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (code)
            4'd0:    return a + b;
            4'd1:    return a << sh;
            4'd2:    return XLEN'($signed(a) < $signed(b));
            4'd3:    return XLEN'(a < b);
            4'd4:    return a ^ b;
            4'd5:    return a >> sh;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a - b;
            4'd13:   return $unsigned($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        res_v    = '0;
        res_pc   = '0;
        res_jump = 1'b0;
        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (cls)
            3'd1: res_v = alu(op[3:0], V1, V2);
            3'd2: begin
                case (sub)
                    // Immediate forms reuse the R-type codes; only SRAI needs op[3].
                    3'd2: res_v = alu((op[2:0] == 3'd5 && op[3]) ? 4'd13 : {1'b0, op[2:0]}, V1, immediate);
                    3'd3: begin
                        res_v    = npc + FOUR;
                        res_pc   = (V1 + immediate) & ~XLEN'(1);
                        res_jump = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                res_jump = 1'b1;
                case (op[2:0])
                    3'd0:    br_taken = (V1 == V2);
                    3'd1:    br_taken = (V1 != V2);
                    3'd4:    br_taken = ($signed(V1) < $signed(V2));
                    3'd5:    br_taken = ($signed(V1) >= $signed(V2));
                    3'd6:    br_taken = (V1 < V2);
                    3'd7:    br_taken = (V1 >= V2);
                    default: br_ok = 1'b0;
                endcase
                if (br_ok) res_pc = br_taken ? npc + immediate : npc + FOUR;
            end
            3'd5: begin
                if (sub == 3'd1) res_v = immediate;
                else if (sub == 3'd2) res_v = npc + immediate;
            end
            3'd6: begin
                res_v    = npc + FOUR;
                res_pc   = npc + immediate;
                res_jump = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef EX_PIPE_MULDIV_EN
    typedef enum logic {IDLE, CALC} state_t;
    state_t               state;
    logic [SHW-1:0]       cnt;
    logic [2*XLEN-1:0]    acc, step_acc, prod;
    logic [XLEN-1:0]      opnd, md_v1, md_res, qn, rn, a_mag, b_mag;
    logic [2:0]           md_f3;
    logic                 md_neg, md_dz, a_s, b_s;
    logic [Q_WIDTH-1:0]   md_tag;
    logic [XLEN:0]        mul_sum, div_rs, div_diff;

    assign idle     = (state == IDLE);
    assign start_md = (cls == 3'd7);
    assign a_s      = V1[XLEN-1] && (op[2:0] inside {3'd1, 3'd2, 3'd4, 3'd6});
    assign b_s      = V2[XLEN-1] && (op[2:0] inside {3'd1, 3'd4, 3'd6});
    assign a_mag    = a_s ? -V1 : V1;
    assign b_mag    = b_s ? -V2 : V2;

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff = div_rs - {1'b0, opnd};
    assign step_acc = !md_f3[2] ? {mul_sum, acc[XLEN-1:1]} :
                      !div_diff[XLEN] ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} :
                                        {div_rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    assign prod     = md_neg ? -step_acc : step_acc;
    assign qn       = md_neg ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    assign rn       = md_neg ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

    always_comb begin
        md_res = '0;
        case (md_f3)
            3'd0:    md_res = prod[XLEN-1:0];
            3'd4:    md_res = md_dz ? '1 : qn;
            3'd5:    md_res = md_dz ? '1 : step_acc[XLEN-1:0];
            3'd6:    md_res = md_dz ? md_v1 : rn;
            3'd7:    md_res = md_dz ? md_v1 : step_acc[2*XLEN-1:XLEN];
            default: md_res = prod[2*XLEN-1:XLEN];
        endcase
    end
`else
    assign idle     = 1'b1;
    assign start_md = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_V       <= '0;
            out_true_pc <= '0;
            out_tag     <= '0;
            out_jump    <= 1'b0;
`ifdef EX_PIPE_MULDIV_EN
            state       <= IDLE;
            cnt         <= '0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
`ifdef EX_PIPE_MULDIV_EN
            state     <= IDLE;
            cnt       <= '0;
`endif
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (accept && !start_md) begin
                out_valid   <= 1'b1;
                out_V       <= res_v;
                out_true_pc <= res_pc;
                out_tag     <= tag;
                out_jump    <= res_jump;
            end
`ifdef EX_PIPE_MULDIV_EN
            if (accept && start_md) begin
                state  <= CALC;
                cnt    <= '0;
                md_f3  <= op[2:0];
                md_neg <= a_s ^ (b_s && op[2:0] != 3'd6);
                md_dz  <= (V2 == '0);
                md_v1  <= V1;
                md_tag <= tag;
                acc    <= {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
                opnd   <= op[2] ? b_mag : a_mag;
            end
            if (state == CALC) begin
                acc <= step_acc;
                cnt <= cnt + SHW'(1);
                if (&cnt) begin
                    out_valid   <= 1'b1;
                    out_V       <= md_res;
                    out_true_pc <= '0;
                    out_tag     <= md_tag;
                    out_jump    <= 1'b0;
                    state       <= IDLE;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_ex_pipe.sv
// Directed and randomized bench for ex_pipe against a behavioural reference model.
module tb_ex_pipe;
    localparam int XLEN = 32;
    localparam int QW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic            in_ready, out_valid, out_jump;
    logic [9:0]      op = '0;
    logic [31:0]     V1 = '0, V2 = '0, immediate = '0, npc = '0;
    logic [QW-1:0]   tag = '0, out_tag;
    logic [31:0]     out_V, out_true_pc;

    int checks = 0;
    int fails  = 0;

    logic            mv;
    logic [31:0]     ev, ept;
    logic [QW-1:0]   etag;
    logic            ej;

    ex_pipe #(.XLEN(XLEN), .Q_WIDTH(QW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .V1(V1), .V2(V2), .immediate(immediate), .npc(npc), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_V(out_V),
        .out_true_pc(out_true_pc), .out_tag(out_tag), .out_jump(out_jump)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", name, obs, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc, input logic [QW-1:0] t);
        in_valid = 1'b1; op = o; V1 = a; V2 = b; immediate = im; npc = pc; tag = t;
    endtask

    // Issue one op with the consumer ready; returns just after the accepting edge.
    task automatic run1(input string name, input logic [9:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] pc, input logic [QW-1:0] t);
        drive(o, a, b, im, pc, t);
        out_ready = 1'b1;
        #1;
        chk1({name, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] ref_r(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            4'd0:    return a + b;
            4'd1:    return a << (b % 32);
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a >> (b % 32);
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a - b;
            4'd13:   return $unsigned($signed(a) >>> (b % 32));
            default: return 32'd0;
        endcase
    endfunction

    function automatic void ref_op(input logic [9:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im, input logic [31:0] pc,
                                   output logic [31:0] v, output logic [31:0] tp, output logic j);
        logic tk, ok;
        v = 0; tp = 0; j = 0; tk = 0; ok = 1;
        case (o[9:7])
            3'd1: v = ref_r(o[3:0], a, b);
            3'd2: begin
                if (o[6:4] == 3'd2) begin
                    case (o[2:0])
                        3'd0: v = a + im;
                        3'd1: v = a << im[4:0];
                        3'd2: v = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
                        3'd3: v = (a < im) ? 32'd1 : 32'd0;
                        3'd4: v = a ^ im;
                        3'd5: v = o[3] ? $unsigned($signed(a) >>> im[4:0]) : a >> im[4:0];
                        3'd6: v = a | im;
                        3'd7: v = a & im;
                    endcase
                end else if (o[6:4] == 3'd3) begin
                    v = pc + 4; tp = (a + im) & 32'hFFFF_FFFE; j = 1;
                end
            end
            3'd4: begin
                j = 1;
                case (o[2:0])
                    3'd0:    tk = (a == b);
                    3'd1:    tk = (a != b);
                    3'd4:    tk = ($signed(a) < $signed(b));
                    3'd5:    tk = ($signed(a) >= $signed(b));
                    3'd6:    tk = (a < b);
                    3'd7:    tk = (a >= b);
                    default: ok = 0;
                endcase
                tp = !ok ? 32'd0 : tk ? pc + im : pc + 4;
            end
            3'd5: begin
                if (o[6:4] == 3'd1) v = im;
                else if (o[6:4] == 3'd2) v = pc + im;
            end
            3'd6: begin
                v = pc + 4; tp = pc + im; j = 1;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, ps;
        logic [63:0] ua, ubu, pu;
        int ia, ib;
        sa = $signed(a); sb = $signed(b); ub = {32'd0, b};
        ua = {32'd0, a}; ubu = {32'd0, b}; ia = a; ib = b;
        case (f)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * ub; return ps[63:32]; end
            3'd3: begin pu = ua * ubu; return pu[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                  else return 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                  else return 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [9:0] rand_op();
        logic [9:0] o;
        o = 10'($urandom);
        if (o[9:7] == 3'd7) o[9:7] = 3'd3;
        if (o[9:7] == 3'd2) o[6:4] = 3'(2 + $urandom_range(0, 3));
        if (o[9:7] == 3'd5) o[6:4] = 3'($urandom_range(0, 3));
        if (o[9:7] == 3'd4 && o[2:1] == 2'b01) o[2] = 1'b1;
        return o;
    endfunction

    initial begin
        int n;
        logic saw;
        // Reset with an issue attempt pending: nothing accepted, everything cleared.
        in_valid = 1'b1; op = 10'h080; tag = 5'd9; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_V", out_V, 32'd0);
        chk32("rst_out_true_pc", out_true_pc, 32'd0);
        chk32("rst_out_tag", 32'(out_tag), 32'd0);
        chk1("rst_out_jump", out_jump, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk1("post_rst_out_valid", out_valid, 1'b0);

        run1("add", 10'h080, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd3);
        chk1("add_valid", out_valid, 1'b1);
        chk32("add_V", out_V, 32'd1);
        chk32("add_tag", 32'(out_tag), 32'd3);
        chk1("add_jump", out_jump, 1'b0);

        run1("blt", 10'h204, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 5'd4);
        chk32("blt_pc", out_true_pc, 32'h120);
        chk1("blt_jump", out_jump, 1'b1);
        chk32("blt_V", out_V, 32'd0);
        run1("bltu", 10'h206, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 5'd5);
        chk32("bltu_pc", out_true_pc, 32'h104);
        chk1("bltu_jump", out_jump, 1'b1);

        run1("sra", 10'h08D, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd6);
        chk32("sra_V", out_V, 32'hF800_0000);

        run1("jalr", 10'h130, 32'h1001, 32'd0, 32'h10, 32'h200, 5'd8);
        chk32("jalr_V", out_V, 32'h204);
        chk32("jalr_pc", out_true_pc, 32'h1010);
        chk1("jalr_jump", out_jump, 1'b1);

        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk1("drain_valid", out_valid, 1'b0);

        // Backpressure: result held, next issue stalled, then retire and accept on one edge.
        drive(10'h080, 32'd5, 32'd6, 32'd0, 32'd0, 5'd7);
        out_ready = 1'b0;
        tick();
        drive(10'h088, 32'd20, 32'd3, 32'd0, 32'd0, 5'd9);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
            chk32("bp_V", out_V, 32'd11);
            chk32("bp_tag", 32'(out_tag), 32'd7);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk1("bp_release_rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1("b2b_valid", out_valid, 1'b1);
        chk32("b2b_V", out_V, 32'd17);
        chk32("b2b_tag", 32'(out_tag), 32'd9);

        // Flush kills the held result and discards the concurrent issue.
        out_ready = 1'b0;
        flush = 1'b1;
        drive(10'h080, 32'd1, 32'd1, 32'd0, 32'd0, 5'd2);
        #1;
        chk1("flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_cleared", out_valid, 1'b0);
        #1;
        chk1("flush_rdy_after", in_ready, 1'b1);
        tick();
        chk1("flush_discarded", out_valid, 1'b0);

        // Mid-run reset clears a loaded result.
        run1("pre_rst", 10'h290, 32'd0, 32'd0, 32'hABCD_0000, 32'd0, 5'd31);
        chk32("lui_V", out_V, 32'hABCD_0000);
        out_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst2_valid", out_valid, 1'b0);
        chk32("rst2_V", out_V, 32'd0);
        chk32("rst2_tag", 32'(out_tag), 32'd0);

        // Randomized traffic with random backpressure against the reference model.
        mv = 1'b0; ev = '0; ept = '0; etag = '0; ej = 1'b0;
        for (int i = 0; i < 400; i++) begin
            chk1("rnd_valid", out_valid, mv);
            if (mv) begin
                chk32("rnd_V", out_V, ev);
                chk32("rnd_pc", out_true_pc, ept);
                chk32("rnd_tag", 32'(out_tag), 32'(etag));
                chk1("rnd_jump", out_jump, ej);
            end
            drive(rand_op(), rand_val(), rand_val(), rand_val(), rand_val(), QW'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk1("rnd_in_ready", in_ready, !mv || out_ready);
            if (in_valid && (!mv || out_ready)) begin
                ref_op(op, V1, V2, immediate, npc, ev, ept, ej);
                etag = tag;
                mv = 1'b1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

`ifdef EX_PIPE_MULDIV_EN
        for (int f = 0; f < 10; f++) begin
            logic [31:0] a, b;
            a = (f == 8) ? 32'h8000_0000 : rand_val();
            b = (f == 8) ? 32'hFFFF_FFFF : (f == 9) ? 32'd0 : rand_val();
            run1("md", {7'b111_0000, (f >= 8) ? 3'd4 + 3'(f - 8) : 3'(f)}, a, b, 32'd0, 32'd0, QW'(f));
            chk1("md_calc_rdy", in_ready, 1'b0);
            n = 1;
            while (out_valid !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            chk32("md_latency", 32'(n), 32'd33);
            chk32("md_V", out_V, ref_md((f >= 8) ? 3'd4 + 3'(f - 8) : 3'(f), a, b));
            chk32("md_tag", 32'(out_tag), 32'(f));
            chk1("md_jump", out_jump, 1'b0);
        end
        tick();

        run1("div_flush", 10'h384, 32'd1000, 32'd7, 32'd0, 32'd0, 5'd21);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk1("md_flush_rdy", in_ready, 1'b1);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid === 1'b1) saw = 1'b1;
        end
        chk1("md_flush_no_result", saw, 1'b0);
`else
        run1("cls7_undef", 10'h384, 32'd1000, 32'd7, 32'd0, 32'd0, 5'd21);
        chk1("cls7_valid", out_valid, 1'b1);
        chk32("cls7_V", out_V, 32'd0);
        chk1("cls7_jump", out_jump, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule
